// File: rtl/prf_read_arbiter.sv
// PRF read-port arbiter: grants up to NUM_GRANT reservation stations a src1/src2
// read-port pair per cycle and routes the returned operands back one cycle later.
module prf_read_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned NUM_GRANT    = 2,
   parameter int unsigned PREG_W       = 6,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [NUM_REQ-1:0]          prf_req,
   input  logic [NUM_REQ-1:0]          exec_ready,
   input  logic [NUM_REQ*PREG_W-1:0]   req_src1_preg,
   input  logic [NUM_REQ*PREG_W-1:0]   req_src2_preg,
   output logic [NUM_REQ-1:0]          prf_grant,
   output logic [NUM_GRANT*PREG_W-1:0] prf_raddr1,
   output logic [NUM_GRANT*PREG_W-1:0] prf_raddr2,
   input  logic [NUM_GRANT*DATA_W-1:0] prf_rdata1,
   input  logic [NUM_GRANT*DATA_W-1:0] prf_rdata2,
   output logic [NUM_REQ-1:0]          rd_valid,
   output logic [NUM_REQ*DATA_W-1:0]   rd_src1_data,
   output logic [NUM_REQ*DATA_W-1:0]   rd_src2_data,
   output logic                        contention
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     wait_q [NUM_REQ];
   logic [CNT_W-1:0]     wait_d [NUM_REQ];
   logic [NUM_GRANT-1:0] s1_valid_q, s1_valid_d;
   logic [NUM_GRANT-1:0] s1_zero1_q, s1_zero1_d;
   logic [NUM_GRANT-1:0] s1_zero2_q, s1_zero2_d;
   logic [PTR_W-1:0]     s1_owner_q [NUM_GRANT];
   logic [PTR_W-1:0]     s1_owner_d [NUM_GRANT];

   logic [PREG_W-1:0]    src1_preg [NUM_REQ];
   logic [PREG_W-1:0]    src2_preg [NUM_REQ];
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   starving;
   logic [NUM_REQ-1:0]   grant_raw;
   logic [NUM_GRANT-1:0] win_vld;
   logic [PTR_W-1:0]     win_idx [NUM_GRANT];
   logic [PREG_W-1:0]    win_p1 [NUM_GRANT];
   logic [PREG_W-1:0]    win_p2 [NUM_GRANT];
   logic                 rr_adv;
   logic [PTR_W-1:0]     rr_win;
   logic                 block;

   assign block      = rst | flush;
   assign eligible   = prf_req & exec_ready;
   assign contention = $countones(eligible) > NUM_GRANT;
   assign prf_grant  = block ? '0 : grant_raw;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         src1_preg[i] = req_src1_preg[i*PREG_W +: PREG_W];
         src2_preg[i] = req_src2_preg[i*PREG_W +: PREG_W];
         starving[i]  = wait_q[i] >= LIMIT;
      end
   end

   // Two passes fill port pairs in order: starving requesters by index, then the
   // round-robin sweep. n_win is the next free port pair.
   always_comb begin : arbitrate
      int unsigned n_win;
      int unsigned idx;
      n_win     = 0;
      idx       = 0;
      grant_raw = '0;
      win_vld   = '0;
      rr_adv    = 1'b0;
      rr_win    = '0;
      for (int unsigned k = 0; k < NUM_GRANT; k++) begin
         win_idx[k] = '0;
         win_p1[k]  = '0;
         win_p2[k]  = '0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (eligible[i] && starving[i] && n_win < NUM_GRANT) begin
            grant_raw[i] = 1'b1;
            for (int unsigned k = 0; k < NUM_GRANT; k++) begin
               if (k == n_win) begin
                  win_vld[k] = 1'b1;
                  win_idx[k] = PTR_W'(i);
                  win_p1[k]  = src1_preg[i];
                  win_p2[k]  = src2_preg[i];
               end
            end
            n_win = n_win + 1;
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         idx = 32'(rr_ptr_q) + j;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i == idx && eligible[i] && !starving[i] && n_win < NUM_GRANT) begin
               grant_raw[i] = 1'b1;
               rr_adv       = 1'b1;
               rr_win       = PTR_W'(i);
               for (int unsigned k = 0; k < NUM_GRANT; k++) begin
                  if (k == n_win) begin
                     win_vld[k] = 1'b1;
                     win_idx[k] = PTR_W'(i);
                     win_p1[k]  = src1_preg[i];
                     win_p2[k]  = src2_preg[i];
                  end
               end
               n_win = n_win + 1;
            end
         end
      end
   end

   always_comb begin
      prf_raddr1 = '0;
      prf_raddr2 = '0;
      for (int unsigned k = 0; k < NUM_GRANT; k++) begin
         if (win_vld[k] && !block) begin
            prf_raddr1[k*PREG_W +: PREG_W] = win_p1[k];
            prf_raddr2[k*PREG_W +: PREG_W] = win_p2[k];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (!flush && rr_adv)
         rr_ptr_d = (32'(rr_win) + 1 == NUM_REQ) ? '0 : rr_win + 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = '0;
         if (!flush && eligible[i] && !grant_raw[i])
            wait_d[i] = (wait_q[i] >= LIMIT) ? LIMIT : wait_q[i] + 1'b1;
      end
      for (int unsigned k = 0; k < NUM_GRANT; k++) begin
         s1_valid_d[k] = win_vld[k] && !flush;
         s1_owner_d[k] = win_idx[k];
         s1_zero1_d[k] = win_p1[k] == '0;
         s1_zero2_d[k] = win_p2[k] == '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         s1_valid_q <= '0;
         s1_zero1_q <= '0;
         s1_zero2_q <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
         for (int unsigned k = 0; k < NUM_GRANT; k++) s1_owner_q[k] <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_zero1_q <= s1_zero1_d;
         s1_zero2_q <= s1_zero2_d;
         for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
         for (int unsigned k = 0; k < NUM_GRANT; k++) s1_owner_q[k] <= s1_owner_d[k];
      end
   end

   // Operand return is masked while rst or flush is high so a read granted the
   // cycle before never reaches the RS.
   always_comb begin
      rd_valid     = '0;
      rd_src1_data = '0;
      rd_src2_data = '0;
      if (!block) begin
         for (int unsigned k = 0; k < NUM_GRANT; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (s1_valid_q[k] && s1_owner_q[k] == PTR_W'(i)) begin
                  rd_valid[i] = 1'b1;
                  rd_src1_data[i*DATA_W +: DATA_W] =
                     s1_zero1_q[k] ? '0 : prf_rdata1[k*DATA_W +: DATA_W];
                  rd_src2_data[i*DATA_W +: DATA_W] =
                     s1_zero2_q[k] ? '0 : prf_rdata2[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: a default instance plus a STARVE_LIMIT=1
// instance that makes the starvation override reachable in a few cycles.
module tb_prf_read_arbiter;

   logic         clk = 1'b0;
   logic         rst, flush;
   logic [3:0]   prf_req, exec_ready;
   logic [23:0]  src1, src2;
   logic [63:0]  rdata1, rdata2;

   logic [3:0]   grant_a, rdv_a, grant_b, rdv_b;
   logic [11:0]  raddr1_a, raddr2_a, raddr1_b, raddr2_b;
   logic [127:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic         cont_a, cont_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prf_read_arbiter #(.NUM_REQ(4), .NUM_GRANT(2), .PREG_W(6), .DATA_W(32), .STARVE_LIMIT(7)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .prf_req(prf_req), .exec_ready(exec_ready),
      .req_src1_preg(src1), .req_src2_preg(src2), .prf_grant(grant_a),
      .prf_raddr1(raddr1_a), .prf_raddr2(raddr2_a), .prf_rdata1(rdata1), .prf_rdata2(rdata2),
      .rd_valid(rdv_a), .rd_src1_data(rd1_a), .rd_src2_data(rd2_a), .contention(cont_a));

   prf_read_arbiter #(.NUM_REQ(4), .NUM_GRANT(2), .PREG_W(6), .DATA_W(32), .STARVE_LIMIT(1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .prf_req(prf_req), .exec_ready(exec_ready),
      .req_src1_preg(src1), .req_src2_preg(src2), .prf_grant(grant_b),
      .prf_raddr1(raddr1_b), .prf_raddr2(raddr2_b), .prf_rdata1(rdata1), .prf_rdata2(rdata2),
      .rd_valid(rdv_b), .rd_src1_data(rd1_b), .rd_src2_data(rd2_b), .contention(cont_b));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_preg(input int i, input logic [5:0] a, input logic [5:0] b);
      src1[i*6 +: 6] = a;
      src2[i*6 +: 6] = b;
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; prf_req = 4'b1111; exec_ready = 4'b1111;
      src1 = '0; src2 = '0; rdata1 = '0; rdata2 = '0;
      set_preg(0, 6'd5, 6'd9);
      set_preg(1, 6'd10, 6'd11);
      set_preg(2, 6'd20, 6'd21);
      set_preg(3, 6'd30, 6'd31);

      // reset held with all requesters eligible
      next_cycle(); #2;
      check("rst_grant", grant_a, 4'b0000);
      check("rst_raddr1", raddr1_a, 12'h000);
      check("rst_rdv", rdv_a, 4'b0000);
      check("rst_grant_b", grant_b, 4'b0000);
      next_cycle(); #2;
      check("rst_grant2", grant_a, 4'b0000);
      check("rst_rd1", rd1_a, 128'h0);

      // single requester 0
      next_cycle();
      rst = 1'b0; prf_req = 4'b0001;
      rdata1 = {32'h11111111, 32'h000000A5};
      rdata2 = {32'h22222222, 32'h00000099};
      #2;
      check("post_rst_rdv", rdv_a, 4'b0000);
      check("post_rst_rd1", rd1_a, 128'h0);
      check("single_grant", grant_a, 4'b0001);
      check("single_raddr1", raddr1_a, 12'h005);
      check("single_raddr2", raddr2_a, 12'h009);
      check("single_cont", cont_a, 1'b0);

      // requester 3 alone: brings rr_ptr back to 0; checks the single read return
      next_cycle();
      prf_req = 4'b1000;
      #2;
      check("single_rdv", rdv_a, 4'b0001);
      check("single_rd1", rd1_a, 128'h000000A5);
      check("single_rd2", rd2_a, 128'h00000099);
      check("r3_grant", grant_a, 4'b1000);
      check("r3_raddr1", raddr1_a, 12'h01E);
      check("r3_raddr2", raddr2_a, 12'h01F);

      // four eligible, rr_ptr=0
      next_cycle();
      prf_req = 4'b1111;
      rdata1 = {32'hBBBB0001, 32'hAAAA0001};
      rdata2 = {32'hBBBB0002, 32'hAAAA0002};
      #2;
      check("r3_rdv", rdv_a, 4'b1000);
      check("r3_rd1", rd1_a, {32'hAAAA0001, 96'h0});
      check("r3_rd2", rd2_a, {32'hAAAA0002, 96'h0});
      check("rr0_grant", grant_a, 4'b0011);
      check("rr0_cont", cont_a, 1'b1);
      check("rr0_raddr1", raddr1_a, 12'h285);
      check("rr0_raddr2", raddr2_a, 12'h2C9);

      // rr_ptr=2
      next_cycle(); #2;
      check("rr0_rdv", rdv_a, 4'b0011);
      check("rr0_rd1", rd1_a, {64'h0, 32'hBBBB0001, 32'hAAAA0001});
      check("rr2_grant", grant_a, 4'b1100);
      check("rr2_cont", cont_a, 1'b1);
      check("rr2_raddr1", raddr1_a, 12'h794);
      check("rr2_raddr2", raddr2_a, 12'h7D5);

      // pointer wrapped back to 0
      next_cycle(); #2;
      check("rr2_rdv", rdv_a, 4'b1100);
      check("rr2_rd1", rd1_a, {32'hBBBB0001, 32'hAAAA0001, 64'h0});
      check("wrap_grant", grant_a, 4'b0011);

      // exec_ready gating, rr_ptr=2: order 2,3,0,1 with 1/3 blocked
      next_cycle();
      exec_ready = 4'b0101;
      #2;
      check("wrap_rdv", rdv_a, 4'b0011);
      check("gate_grant", grant_a, 4'b0101);
      check("gate_cont", cont_a, 1'b0);
      check("gate_raddr1", raddr1_a, 12'h154);
      check("gate_raddr2", raddr2_a, 12'h255);

      next_cycle();
      prf_req = 4'b0000; exec_ready = 4'b1111;
      #2;
      check("gate_rdv", rdv_a, 4'b0101);
      check("gate_rd1", rd1_a, {32'h0, 32'hAAAA0001, 32'h0, 32'hBBBB0001});
      check("gate_rd2", rd2_a, {32'h0, 32'hAAAA0002, 32'h0, 32'hBBBB0002});
      check("idle_grant", grant_a, 4'b0000);

      // src1 preg 0 must read as zero even though the PRF returns garbage
      next_cycle();
      prf_req = 4'b0010;
      set_preg(1, 6'd0, 6'd11);
      rdata1 = {32'hBBBB0001, 32'h0000DEAD};
      #2;
      check("zero_grant", grant_a, 4'b0010);
      check("zero_raddr1", raddr1_a, 12'h000);
      check("zero_raddr2", raddr2_a, 12'h00B);

      next_cycle();
      prf_req = 4'b0000;
      #2;
      check("zero_rdv", rdv_a, 4'b0010);
      check("zero_rd1", rd1_a, 128'h0);
      check("zero_rd2", rd2_a, {64'h0, 32'hAAAA0002, 32'h0});

      // flush: grant here (rr_ptr=2, winners 2 then 0 -> rr_ptr=1)
      next_cycle();
      set_preg(1, 6'd10, 6'd11);
      rdata1 = {32'hBBBB0001, 32'hAAAA0001};
      prf_req = 4'b0111;
      #2;
      check("pre_flush_grant", grant_a, 4'b0101);
      check("pre_flush_raddr1", raddr1_a, 12'h154);

      next_cycle();
      flush = 1'b1; prf_req = 4'b1111;
      #2;
      check("flush_grant", grant_a, 4'b0000);
      check("flush_rdv", rdv_a, 4'b0000);
      check("flush_raddr1", raddr1_a, 12'h000);

      // rr_ptr kept at 1 through the flush
      next_cycle();
      flush = 1'b0;
      #2;
      check("post_flush_rdv", rdv_a, 4'b0000);
      check("post_flush_grant", grant_a, 4'b0110);
      check("post_flush_raddr1", raddr1_a, 12'h50A);

      // reset mid-pipeline, second cycle also with flush
      next_cycle();
      rst = 1'b1;
      #2;
      check("midrst_grant", grant_a, 4'b0000);
      check("midrst_rdv", rdv_a, 4'b0000);
      check("midrst_raddr1", raddr1_a, 12'h000);

      next_cycle();
      flush = 1'b1;
      #2;
      check("rstflush_grant", grant_a, 4'b0000);
      check("rstflush_rdv", rdv_a, 4'b0000);

      next_cycle();
      rst = 1'b0; flush = 1'b0;
      #2;
      check("after_midrst_rdv", rdv_a, 4'b0000);
      check("after_midrst_grant", grant_a, 4'b0011);

      // starvation override on the STARVE_LIMIT=1 instance
      next_cycle();
      rst = 1'b1; prf_req = 4'b0000;
      #2;
      next_cycle();
      rst = 1'b0; prf_req = 4'b1011;
      #2;
      check("starve_setup_grant", grant_b, 4'b0011);

      // 3 starving -> port 0 despite rr_ptr=2; 2 follows on port 1
      next_cycle();
      prf_req = 4'b1111;
      #2;
      check("starve_setup_rdv", rdv_b, 4'b0011);
      check("starve_setup_rd1", rd1_b, {64'h0, 32'hBBBB0001, 32'hAAAA0001});
      check("starve3_grant", grant_b, 4'b1100);
      check("starve3_raddr1", raddr1_b, 12'h51E);
      check("starve3_cont", cont_b, 1'b1);

      // 0 and 1 now starving, lowest index first
      next_cycle(); #2;
      check("starve3_rdv", rdv_b, 4'b1100);
      check("starve3_rd1", rd1_b, {32'hAAAA0001, 32'hBBBB0001, 64'h0});
      check("starve01_grant", grant_b, 4'b0011);
      check("starve01_raddr1", raddr1_b, 12'h285);

      next_cycle(); #2;
      check("starve23_grant", grant_b, 4'b1100);
      check("starve23_raddr1", raddr1_b, 12'h794);

      // flush clears wait counters; rr_ptr stays 3 from the last RR winner
      next_cycle();
      flush = 1'b1;
      #2;
      check("flush_b_grant", grant_b, 4'b0000);
      check("flush_b_rdv", rdv_b, 4'b0000);

      next_cycle();
      flush = 1'b0;
      #2;
      check("post_flush_b_grant", grant_b, 4'b1001);
      check("post_flush_b_raddr1", raddr1_b, 12'h15E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
